// File: rtl/branch_ctrl.sv
// branch_ctrl: 2-bit BHT/BTB branch predictor with ID-stage branch resolution, redirect and stats.
module branch_ctrl #(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic        id_is_branch,
    input  logic [2:0]  id_funct3,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_rs1_val,
    input  logic [31:0] id_rs2_val,
    input  logic        id_pred_taken,
    input  logic [31:0] id_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        illegal_br,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);
    localparam int IDX = $clog2(BHT_ENTRIES);
    logic [1:0]             cnt [BHT_ENTRIES];
    logic [31:0]            btb [BHT_ENTRIES];
    logic [BHT_ENTRIES-1:0] vld;
    logic [IDX-1:0]         if_idx, id_idx;
    logic [1:0]             cnt_nxt;
    logic [31:0]            tgt, fall;
    logic                   res, br_res, alias_res, eq, lt, ltu, taken, mispred;
    assign if_idx      = if_pc[IDX+1:2];
    assign id_idx      = id_pc[IDX+1:2];
    assign pred_taken  = rst_n & vld[if_idx] & cnt[if_idx][1];
    assign pred_target = (rst_n & vld[if_idx]) ? btb[if_idx] : '0;
    assign res         = id_valid & ~id_stall;
    assign br_res      = res & id_is_branch;
    // a non-branch that was predicted taken is a BTB alias and must be squashed
    assign alias_res   = res & ~id_is_branch & id_pred_taken;
    assign tgt         = id_pc + id_imm;
    assign fall        = id_pc + 32'd4;
    assign eq          = id_rs1_val == id_rs2_val;
    assign lt          = $signed(id_rs1_val) < $signed(id_rs2_val);
    assign ltu         = id_rs1_val < id_rs2_val;
    assign taken       = id_funct3 == 3'd0 ? eq  :
                         id_funct3 == 3'd1 ? ~eq :
                         id_funct3 == 3'd4 ? lt  :
                         id_funct3 == 3'd5 ? ~lt :
                         id_funct3 == 3'd6 ? ltu :
                         id_funct3 == 3'd7 ? ~ltu : 1'b0;
    assign mispred     = (br_res & ((taken != id_pred_taken) | (taken & (id_pred_target != tgt)))) | alias_res;
    assign illegal_br  = rst_n & br_res & (id_funct3[2:1] == 2'b01);
    assign redirect    = rst_n & mispred;
    assign redirect_pc = rst_n ? ((br_res & taken) ? tgt : fall) : '0;
    assign cnt_nxt     = taken ? (cnt[id_idx] == 2'b11 ? 2'b11 : cnt[id_idx] + 2'b01)
                               : (cnt[id_idx] == 2'b00 ? 2'b00 : cnt[id_idx] - 2'b01);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt[i] <= 2'b01;
                btb[i] <= '0;
            end
            vld           <= '0;
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (br_res) begin
                cnt[id_idx] <= cnt_nxt;
                br_count    <= br_count + 32'd1;
                if (taken) begin
                    btb[id_idx] <= tgt;
                    vld[id_idx] <= 1'b1;
                end
            end
            if (alias_res) vld[id_idx] <= 1'b0;
            if (mispred) mispred_count <= mispred_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed scoreboard bench for branch_ctrl.
module tb_branch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid, id_stall, id_is_branch, id_pred_taken;
    logic [2:0]  id_funct3;
    logic [31:0] id_pc, id_imm, id_rs1_val, id_rs2_val, id_pred_target;
    logic        redirect, illegal_br;
    logic [31:0] redirect_pc, br_count, mispred_count;
    logic [31:0] q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          exp_br = 0;
    int          exp_mis = 0;

    branch_ctrl #(.BHT_ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .id_valid(id_valid), .id_stall(id_stall), .id_is_branch(id_is_branch), .id_funct3(id_funct3),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target), .redirect(redirect),
        .redirect_pc(redirect_pc), .illegal_br(illegal_br), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_assert++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic e_t, input logic [31:0] e_tgt);
        if_pc = pc;
        q.push_back({31'd0, e_t});
        q.push_back(e_tgt);
        #1;
        chk("pred_taken", {31'd0, pred_taken});
        chk("pred_target", pred_target);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic pt,
                         input logic [31:0] ptgt, input logic isb);
        id_valid = 1'b1; id_stall = 1'b0; id_is_branch = isb; id_funct3 = f3; id_pc = pc;
        id_imm = imm; id_rs1_val = a; id_rs2_val = b; id_pred_taken = pt; id_pred_target = ptgt;
    endtask

    task automatic expect_out(input logic e_red, input logic [31:0] e_pc, input logic e_ill);
        q.push_back({31'd0, e_red});
        q.push_back({31'd0, e_ill});
        if (e_red) q.push_back(e_pc);
        #1;
        chk("redirect", {31'd0, redirect});
        chk("illegal_br", {31'd0, illegal_br});
        if (e_red) chk("redirect_pc", redirect_pc);
    endtask

    task automatic counts();
        q.push_back(exp_br);
        q.push_back(exp_mis);
        #1;
        chk("br_count", br_count);
        chk("mispred_count", mispred_count);
    endtask

    task automatic commit(input logic isb, input logic e_red);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        id_stall = 1'b0;
        if (isb) exp_br++;
        if (e_red) exp_mis++;
        counts();
    endtask

    initial begin
        rst_n = 1'b0; if_pc = 32'h100;
        drive(32'h100, 32'h40, 3'd3, 5, 5, 1'b1, 32'h999, 1'b1);
        #2;
        expect_out(1'b0, 0, 1'b0);
        q.push_back(32'h0);
        chk("redirect_pc_rst", redirect_pc);
        look(32'h100, 1'b0, 32'h0);
        counts();
        id_valid = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        look(32'h100, 1'b0, 32'h0);
        counts();
        // first taken BEQ: lookup in the same cycle still sees the old entry
        drive(32'h100, 32'h40, 3'd0, 5, 5, 1'b0, 32'h0, 1'b1);
        look(32'h100, 1'b0, 32'h0);
        expect_out(1'b1, 32'h140, 1'b0);
        commit(1'b1, 1'b1);
        look(32'h100, 1'b1, 32'h140);
        repeat (3) begin
            drive(32'h100, 32'h40, 3'd0, 5, 5, 1'b1, 32'h140, 1'b1);
            expect_out(1'b0, 0, 1'b0);
            commit(1'b1, 1'b0);
        end
        look(32'h100, 1'b1, 32'h140);
        drive(32'h100, 32'h40, 3'd0, 1, 2, 1'b1, 32'h140, 1'b1);
        expect_out(1'b1, 32'h104, 1'b0);
        commit(1'b1, 1'b1);
        look(32'h100, 1'b1, 32'h140);
        drive(32'h100, 32'h40, 3'd0, 1, 2, 1'b1, 32'h140, 1'b1);
        expect_out(1'b1, 32'h104, 1'b0);
        commit(1'b1, 1'b1);
        look(32'h100, 1'b0, 32'h140);
        drive(32'h208, 32'h10, 3'd4, 32'hFFFFFFFF, 1, 1'b0, 32'h0, 1'b1);
        expect_out(1'b1, 32'h218, 1'b0);
        commit(1'b1, 1'b1);
        look(32'h208, 1'b1, 32'h218);
        drive(32'h208, 32'h10, 3'd4, 32'hFFFFFFFF, 1, 1'b1, 32'h999, 1'b1);
        expect_out(1'b1, 32'h218, 1'b0);
        commit(1'b1, 1'b1);
        drive(32'h20C, 32'h10, 3'd6, 32'hFFFFFFFF, 1, 1'b0, 32'h0, 1'b1);
        expect_out(1'b0, 0, 1'b0);
        commit(1'b1, 1'b0);
        look(32'h20C, 1'b0, 32'h0);
        drive(32'h210, 32'hFFFFFFF8, 3'd7, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h0, 1'b1);
        expect_out(1'b1, 32'h208, 1'b0);
        commit(1'b1, 1'b1);
        drive(32'h214, 32'h10, 3'd5, 32'hFFFFFFFF, 1, 1'b1, 32'h224, 1'b1);
        expect_out(1'b1, 32'h218, 1'b0);
        commit(1'b1, 1'b1);
        drive(32'h230, 32'h10, 3'd1, 3, 4, 1'b1, 32'h240, 1'b1);
        expect_out(1'b0, 0, 1'b0);
        commit(1'b1, 1'b0);
        drive(32'h218, 32'h10, 3'd3, 5, 5, 1'b0, 32'h0, 1'b1);
        expect_out(1'b0, 0, 1'b1);
        commit(1'b1, 1'b0);
        expect_out(1'b0, 0, 1'b0);
        drive(32'h218, 32'h10, 3'd2, 5, 5, 1'b1, 32'h300, 1'b1);
        expect_out(1'b1, 32'h21C, 1'b1);
        commit(1'b1, 1'b1);
        // stalled branch resolves exactly once, on the first unstalled cycle
        drive(32'h220, 32'h20, 3'd0, 7, 7, 1'b0, 32'h0, 1'b1);
        id_stall = 1'b1;
        repeat (3) begin
            expect_out(1'b0, 0, 1'b0);
            @(posedge clk); #1;
        end
        counts();
        id_stall = 1'b0;
        expect_out(1'b1, 32'h240, 1'b0);
        commit(1'b1, 1'b1);
        drive(32'h1FC, 32'h10, 3'd0, 1, 1, 1'b0, 32'h0, 1'b1);
        expect_out(1'b1, 32'h20C, 1'b0);
        commit(1'b1, 1'b1);
        look(32'h1FC, 1'b1, 32'h20C);
        drive(32'h1FC, 32'h0, 3'd0, 0, 0, 1'b1, 32'h20C, 1'b0);
        expect_out(1'b1, 32'h200, 1'b0);
        commit(1'b0, 1'b1);
        look(32'h1FC, 1'b0, 32'h0);
        drive(32'h1FC, 32'h0, 3'd0, 0, 0, 1'b0, 32'h0, 1'b0);
        expect_out(1'b0, 0, 1'b0);
        commit(1'b0, 1'b0);
        drive(32'hFFFFFFFC, 32'h8, 3'd0, 9, 9, 1'b0, 32'h0, 1'b1);
        expect_out(1'b1, 32'h4, 1'b0);
        commit(1'b1, 1'b1);
        look(32'hFFFFFFFC, 1'b1, 32'h4);
        // reset mid-cycle discards the pending update
        drive(32'h100, 32'h40, 3'd0, 5, 5, 1'b0, 32'h0, 1'b1);
        #3 rst_n = 1'b0;
        expect_out(1'b0, 0, 1'b0);
        q.push_back(32'h0);
        chk("redirect_pc_rst", redirect_pc);
        look(32'h100, 1'b0, 32'h0);
        exp_br = 0;
        exp_mis = 0;
        counts();
        id_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        look(32'h100, 1'b0, 32'h0);
        look(32'hFFFFFFFC, 1'b0, 32'h0);
        counts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch prediction and resolution controller for the 5-stage RV32 pipeline. It looks up a direction/target prediction for the IF-stage PC and resolves conditional branches in ID with the six RV32 branch compare operations. On a mispredict it redirects fetch and flushes IF, and it trains its 2-bit counter table and target buffer. It also keeps branch and mispredict statistics counters for performance debug.

## Interface
- BHT_ENTRIES, 16, number of predictor entries; power of two, 4..256; IDX = log2(BHT_ENTRIES)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  32  PC of instruction currently in IF
- pred_taken  out  1  IF prediction: entry valid and counter[1]==1
- pred_target  out  32  IF predicted target (BTB entry), 0 when entry invalid
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_stall  in  1  ID frozen this cycle (hazard unit); suppresses resolution
- id_is_branch  in  1  ID instruction is a conditional branch
- id_funct3  in  3  branch funct3
- id_pc  in  32  PC of ID instruction
- id_imm  in  32  sign-extended B-type immediate
- id_rs1_val, id_rs2_val  in  32 each  forwarded operands
- id_pred_taken  in  1  pred_taken carried IF->ID with the instruction
- id_pred_target  in  32  pred_target carried IF->ID
- redirect  out  1  fetch must go to redirect_pc next cycle; IF must be flushed
- redirect_pc  out  32  corrected fetch address
- illegal_br  out  1  branch with funct3 = 2 or 3
- br_count  out  32  resolved-branch counter
- mispred_count  out  32  mispredict counter

## Operation
- Index: idx = pc[IDX+1:2]. State per entry: 2-bit counter, BTB valid bit, 32-bit target.
- Lookup (IF, combinational): reads state as held before the current edge.
- Resolve condition: res = id_valid & ~id_stall. Without res: no redirect, no update, no counting.
- Compare on funct3: 0 eq, 1 ne, 4 signed lt, 5 signed ge, 6 unsigned lt, 7 unsigned ge. funct3 2/3 give not-taken with illegal_br=1 (only when res & id_is_branch).
- Target: tgt = id_pc + id_imm, mod 2^32. Fall-through: id_pc + 4, mod 2^32.
- Branch, res:
  - mispredict = (taken != id_pred_taken) | (taken & id_pred_target != tgt).
  - redirect_pc = taken ? tgt : id_pc+4.
  - Counter +1 on taken, -1 on not-taken, saturating at 3 and 0.
  - On taken: BTB target <= tgt and valid <= 1.
  - br_count +1. mispred_count +1 when mispredict.
- Non-branch, res, id_pred_taken=1 (alias):
  - redirect=1, redirect_pc = id_pc+4.
  - Clear valid at idx(id_pc); counter unchanged.
  - mispred_count +1; br_count unchanged.
- Counters wrap from 0xFFFFFFFF to 0.
- Lookup and update to the same idx in one cycle: lookup returns the old value; the update is visible from the next cycle.

## Timing
- Reset (async assert, sync-safe deassert by top): all counters = 2'b01, all valid = 0, targets = 0, br_count = mispred_count = 0.
- While rst_n=0, outputs are forced: pred_taken=0, pred_target=0, redirect=0, redirect_pc=0, illegal_br=0.
- Prediction outputs: 0-cycle latency (combinational from if_pc).
- redirect, redirect_pc, illegal_br: combinational in the ID cycle. Fetch uses redirect_pc at the next edge and the IF instruction is squashed, so the penalty is 1 bubble.
- Table and stat updates land at the edge ending the resolving cycle.
- Reset asserted mid-cycle: state clears immediately; pending update is discarded.
- id_stall held N cycles: exactly one resolution/update occurs, in the first cycle with id_stall=0.

## Test plan
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0. br_count=0.
- BEQ at 0x100, imm=0x40, rs1=rs2=5, id_pred_taken=0 -> redirect=1, redirect_pc=0x140, mispred_count=1. Next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x140.
- Same branch taken 3 more times, then not taken (rs1=1, rs2=2) -> counter saturates at 3 and then reads 2. Prediction stays taken; the not-taken one redirects to 0x104.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken. BGEU 0x80000000 vs 0x7FFFFFFF -> taken.
- funct3=3 with res -> illegal_br=1 and a not-taken result. id_stall=1 for 3 cycles -> br_count increments once.
- Non-branch at a predicted-taken PC (pc=0x1FC) -> redirect_pc=0x200 and entry invalidated. Branch at pc=0xFFFFFFFC, imm=8 -> tgt=0x4 (wrap).
